// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, shared-ALU and response signals around alu_arbiter.
// slave  : arbiter side (takes requests and ALU results, drives grants, ALU operands, response).
// master : environment side (requesters, ALU and response consumer).
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic [1:0]  req0_sel;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic [1:0]  req1_sel;
  logic [15:0] alu_ina;
  logic [15:0] alu_inb;
  logic [1:0]  alu_sel;
  logic [15:0] alu_out;
  logic        alu_ovf;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_ovf;
  logic        rsp_dz;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  alu_out, alu_ovf, rsp_ready,
    output req0_ready, req1_ready,
    output alu_ina, alu_inb, alu_sel,
    output rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_dz, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output alu_out, alu_ovf, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_ina, alu_inb, alu_sel,
    input  rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_dz, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between two requesters.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_arbiter_if.slave -- request handshakes (req0/req1), shared ALU
//           operands/results (alu_*), response handshake (rsp_*) and busy.
// One operation is in flight at a time: IDLE accepts, EXEC waits WAIT_CYC
// settle cycles, RESP holds the captured result until the consumer takes it.
module alu_arbiter #(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  localparam int unsigned DW = 16;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_grant_q, last_grant_d;
  logic [DW-1:0]  op_a_q, op_a_d;
  logic [DW-1:0]  op_b_q, op_b_d;
  logic [SW-1:0]  op_sel_q, op_sel_d;
  logic           op_id_q, op_id_d;
  logic           rsp_id_q, rsp_id_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic           rsp_dz_q, rsp_dz_d;

  logic           grant_vld_c;
  logic           grant_id_c;
  logic           ready0_c;
  logic           ready1_c;
  logic           div_zero_c;

  // Grant selection: lone requester wins, a tie goes opposite to the last grant.
  always_comb begin
    grant_vld_c = bus.req0_valid | bus.req1_valid;
    grant_id_c  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id_c = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant_id_c = 1'b1;
    end
  end

  assign div_zero_c = (op_sel_q == SW'(3)) && (op_b_q == DW'(0));

  // Next-state, operand latch and result capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    op_id_d      = op_id_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_dz_d     = rsp_dz_q;
    ready0_c     = 1'b0;
    ready1_c     = 1'b0;

    case (state_q)
      IDLE: begin
        ready0_c = grant_vld_c & ~grant_id_c;
        ready1_c = grant_vld_c &  grant_id_c;
        // The granted requester sees ready=1 while valid=1, so any grant is an accept.
        if (grant_vld_c) begin
          op_a_d       = grant_id_c ? bus.req1_a   : bus.req0_a;
          op_b_d       = grant_id_c ? bus.req1_b   : bus.req0_b;
          op_sel_d     = grant_id_c ? bus.req1_sel : bus.req0_sel;
          op_id_d      = grant_id_c;
          last_grant_d = grant_id_c;
          cnt_d        = CW'(WAIT_CYC);
          state_d      = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CW'(1);
        // Counter reaching 1 marks the WAIT_CYC-th edge after acceptance.
        if (cnt_q == CW'(1)) begin
          rsp_id_d = op_id_q;
          if (div_zero_c) begin
            rsp_data_d = {DW{1'b1}};
            rsp_ovf_d  = 1'b1;
            rsp_dz_d   = 1'b1;
          end else begin
            rsp_data_d = bus.alu_out;
            rsp_ovf_d  = bus.alu_ovf;
            rsp_dz_d   = 1'b0;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= '0;
      op_id_q      <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_dz_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      op_id_q      <= op_id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_dz_q     <= rsp_dz_d;
    end
  end

  assign bus.req0_ready = ready0_c;
  assign bus.req1_ready = ready1_c;
  assign bus.alu_ina    = op_a_q;
  assign bus.alu_inb    = op_b_q;
  assign bus.alu_sel    = op_sel_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.rsp_dz     = rsp_dz_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (WAIT_CYC=2) with a behavioural shared ALU.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_arbiter_if bus ();

  alu_arbiter #(.WAIT_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: add carry, sub borrow, mul high-half nonzero; div-by-zero returns junk.
  logic [16:0] alu_sum;
  logic [16:0] alu_dif;
  logic [31:0] alu_prod;
  assign alu_sum  = {1'b0, bus.alu_ina} + {1'b0, bus.alu_inb};
  assign alu_dif  = {1'b0, bus.alu_ina} - {1'b0, bus.alu_inb};
  assign alu_prod = {16'h0, bus.alu_ina} * {16'h0, bus.alu_inb};
  always_comb begin
    bus.alu_out = 16'h0000;
    bus.alu_ovf = 1'b0;
    case (bus.alu_sel)
      2'b00: begin bus.alu_out = alu_sum[15:0]; bus.alu_ovf = alu_sum[16]; end
      2'b01: begin bus.alu_out = alu_dif[15:0]; bus.alu_ovf = alu_dif[16]; end
      2'b10: begin bus.alu_out = alu_prod[15:0]; bus.alu_ovf = |alu_prod[31:16]; end
      default: begin
        if (bus.alu_inb == 16'h0000) bus.alu_out = 16'hDEAD;
        else bus.alu_out = bus.alu_ina / bus.alu_inb;
      end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit id, input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_sel = sel; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_sel = sel; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = '0;
    bus.rsp_ready = 1'b0;
    step(); step();
    checks++;
    if ({bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_ovf, bus.rsp_dz, bus.alu_sel, bus.req1_ready, bus.req0_ready} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl got busy=%b rv=%b id=%b ovf=%b dz=%b sel=%b rdy=%b%b exp all 0",
        bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_ovf, bus.rsp_dz, bus.alu_sel, bus.req1_ready, bus.req0_ready);
    end
    checks++;
    if ({bus.alu_ina, bus.alu_inb, bus.rsp_data} !== 48'h0) begin
      errors++; $display("FAIL reset_data got ina=%h inb=%h data=%h exp 0", bus.alu_ina, bus.alu_inb, bus.rsp_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    bus.rsp_ready = 1'b1;
    drive_req(1'b0, 2'b00, 16'h0003, 16'h0004);
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++; $display("FAIL add_grant got %b%b exp 01", bus.req1_ready, bus.req0_ready);
    end
    step();
    bus.req0_valid = 1'b0;
    checks++;
    if ({bus.busy, bus.rsp_valid, bus.alu_ina, bus.alu_inb, bus.alu_sel} !== {1'b1, 1'b0, 16'h0003, 16'h0004, 2'b00}) begin
      errors++; $display("FAIL add_exec got busy=%b rv=%b ina=%h inb=%h sel=%b exp 1 0 0003 0004 00",
        bus.busy, bus.rsp_valid, bus.alu_ina, bus.alu_inb, bus.alu_sel);
    end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_early got rsp_valid=%b exp 0", bus.rsp_valid);
    end
    step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz} !== {1'b1, 1'b0, 16'h0007, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_rsp got v=%b id=%b data=%h ovf=%b dz=%b exp 1 0 0007 0 0",
        bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz);
    end
    step();
    checks++;
    if ({bus.rsp_valid, bus.busy, bus.rsp_data} !== {1'b0, 1'b0, 16'h0007}) begin
      errors++; $display("FAIL add_done got v=%b busy=%b data=%h exp 0 0 0007", bus.rsp_valid, bus.busy, bus.rsp_data);
    end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    drive_req(1'b0, 2'b01, 16'h000A, 16'h0003);
    drive_req(1'b1, 2'b10, 16'h0100, 16'h0100);
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++; $display("FAIL rr_tie1 got %b%b exp 01", bus.req1_ready, bus.req0_ready);
    end
    step();
    drive_req(1'b0, 2'b00, 16'h8000, 16'h8000);
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready, bus.alu_sel} !== 4'b0001) begin
      errors++; $display("FAIL rr_exec1 got rdy=%b%b sel=%b exp 00 01", bus.req1_ready, bus.req0_ready, bus.alu_sel);
    end
    step(); step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz} !== {1'b1, 1'b0, 16'h0007, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rr_rsp1 got v=%b id=%b data=%h ovf=%b dz=%b exp 1 0 0007 0 0",
        bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz);
    end
    step();
    checks++;
    if ({bus.rsp_valid, bus.req1_ready, bus.req0_ready} !== 3'b010) begin
      errors++; $display("FAIL rr_tie2 got v=%b rdy=%b%b exp 0 10", bus.rsp_valid, bus.req1_ready, bus.req0_ready);
    end
    step();
    drive_req(1'b1, 2'b01, 16'h0000, 16'h0001);
    checks++;
    if (bus.alu_sel !== 2'b10) begin
      errors++; $display("FAIL rr_exec2 got sel=%b exp 10", bus.alu_sel);
    end
    step(); step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz} !== {1'b1, 1'b1, 16'h0000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rr_rsp2 got v=%b id=%b data=%h ovf=%b dz=%b exp 1 1 0000 1 0",
        bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz);
    end
    step();
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++; $display("FAIL rr_tie3 got %b%b exp 01", bus.req1_ready, bus.req0_ready);
    end
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step(); step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz} !== {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rr_rsp3 got v=%b id=%b data=%h ovf=%b dz=%b exp 1 0 0000 1 0",
        bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz);
    end
    step();
  endtask

  task automatic test_div();
    bus.rsp_ready = 1'b1;
    drive_req(1'b1, 2'b11, 16'h0010, 16'h0000);
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
      errors++; $display("FAIL dz_grant got %b%b exp 10", bus.req1_ready, bus.req0_ready);
    end
    step();
    bus.req1_valid = 1'b0;
    step(); step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz} !== {1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1}) begin
      errors++; $display("FAIL dz_rsp got v=%b id=%b data=%h ovf=%b dz=%b exp 1 1 ffff 1 1",
        bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz);
    end
    step();
    drive_req(1'b1, 2'b11, 16'h0010, 16'h0004);
    step();
    bus.req1_valid = 1'b0;
    step(); step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz} !== {1'b1, 1'b1, 16'h0004, 1'b0, 1'b0}) begin
      errors++; $display("FAIL div_rsp got v=%b id=%b data=%h ovf=%b dz=%b exp 1 1 0004 0 0",
        bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz);
    end
    step();
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 2'b00, 16'h0001, 16'h0002);
    step();
    bus.req0_valid = 1'b0;
    drive_req(1'b1, 2'b00, 16'h0009, 16'h0009);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.busy, bus.req1_ready, bus.req0_ready, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz}
          !== {1'b1, 1'b1, 2'b00, 1'b0, 16'h0003, 1'b0, 1'b0}) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b busy=%b rdy=%b%b id=%b data=%h ovf=%b dz=%b exp 1 1 00 0 0003 0 0",
          i, bus.rsp_valid, bus.busy, bus.req1_ready, bus.req0_ready, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz);
      end
      step();
    end
    // req1 withdraws without ever being granted.
    bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL bp_release got v=%b busy=%b exp 00", bus.rsp_valid, bus.busy);
    end
    step(); step();
    checks++;
    if ({bus.rsp_valid, bus.busy, bus.req1_ready, bus.req0_ready} !== 4'b0000) begin
      errors++; $display("FAIL withdraw got v=%b busy=%b rdy=%b%b exp 0 0 00", bus.rsp_valid, bus.busy, bus.req1_ready, bus.req0_ready);
    end
  endtask

  task automatic test_reset_mid_exec();
    bus.rsp_ready = 1'b1;
    drive_req(1'b0, 2'b10, 16'h0003, 16'h0005);
    step();
    bus.req0_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre got busy=%b exp 1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_ovf, bus.rsp_dz, bus.alu_sel} !== 7'b0) begin
      errors++; $display("FAIL rst_async_ctrl got busy=%b v=%b id=%b ovf=%b dz=%b sel=%b exp all 0",
        bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_ovf, bus.rsp_dz, bus.alu_sel);
    end
    checks++;
    if ({bus.alu_ina, bus.alu_inb, bus.rsp_data} !== 48'h0) begin
      errors++; $display("FAIL rst_async_data got ina=%h inb=%h data=%h exp 0", bus.alu_ina, bus.alu_inb, bus.rsp_data);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
        errors++; $display("FAIL rst_no_rsp[%0d] got v=%b busy=%b exp 00", i, bus.rsp_valid, bus.busy);
      end
    end
    drive_req(1'b0, 2'b00, 16'h00FF, 16'h0001);
    step();
    bus.req0_valid = 1'b0;
    step(); step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz} !== {1'b1, 1'b0, 16'h0100, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_after got v=%b id=%b data=%h ovf=%b dz=%b exp 1 0 0100 0 0",
        bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_dz);
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_round_robin();
    test_div();
    test_backpressure();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
